// File: rtl/regf_pkg.sv
// Shared register-file definitions used by the writeback controller, register file and hazard unit.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents:
//   XLEN        architectural data width
//   REG_ADDR_W  register address width
//   REG_X0      address of the hard-wired zero register
//   wb_req_t    one writeback request {rd, data}
package regf_pkg;

   localparam int XLEN       = 32;
   localparam int REG_ADDR_W = 5;

   localparam logic [REG_ADDR_W-1:0] REG_X0 = 5'd0;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] rd;
      logic [XLEN-1:0]       data;
   } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// Circular FIFO holding LSU writebacks; exposes head peek plus per-entry {valid, rd} for hazard compare.
// Latency: a pushed entry is visible at the head on the cycle after the push edge.
// Backpressure: push is ignored when full and pop is ignored when empty; the caller gates both.
//
// Ports:
//   clk, rst            clock, async active-high reset (empties the FIFO)
//   push, push_rd/data  enqueue one entry
//   pop                 dequeue the head entry
//   head_rd/head_data   current head (valid while count != 0)
//   count               occupancy, one extra bit so full and empty differ
//   ent_vld, ent_rd     per-slot valid flag and destination register
module wb_fifo
   import regf_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int DEPTH = 4
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 push,
   input  logic [REG_ADDR_W-1:0]                push_rd,
   input  logic [XLEN-1:0]                      push_data,
   input  logic                                 pop,
   output logic [REG_ADDR_W-1:0]                head_rd,
   output logic [XLEN-1:0]                      head_data,
   output logic [$clog2(DEPTH):0]               count,
   output logic [DEPTH-1:0]                     ent_vld,
   output logic [DEPTH-1:0][REG_ADDR_W-1:0]     ent_rd
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [XLEN-1:0]       mem_data [DEPTH];
   logic [REG_ADDR_W-1:0] mem_rd   [DEPTH];
   logic [PTR_W-1:0]      wr_ptr;
   logic [PTR_W-1:0]      rd_ptr;
   logic                  push_en;
   logic                  pop_en;

   assign push_en = push && (count != FULL_CNT);
   assign pop_en  = pop  && (count != '0);

   // Pointers are PTR_W bits wide, so they wrap modulo DEPTH on their own.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_en) wr_ptr <= wr_ptr + 1'b1;
         if (pop_en)  rd_ptr <= rd_ptr + 1'b1;
         case ({push_en, pop_en})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset: every slot is qualified by ent_vld / count.
   always_ff @(posedge clk) begin
      if (push_en) begin
         mem_data[wr_ptr] <= push_data;
         mem_rd[wr_ptr]   <= push_rd;
      end
   end

   assign head_rd   = mem_rd[rd_ptr];
   assign head_data = mem_data[rd_ptr];

   // A slot is live when its distance from the read pointer is below the occupancy.
   always_comb begin
      ent_vld = '0;
      ent_rd  = '0;
      for (int i = 0; i < DEPTH; i++) begin
         logic [PTR_W-1:0] off;
         off        = PTR_W'(i) - rd_ptr;
         ent_vld[i] = ({1'b0, off} < count);
         ent_rd[i]  = mem_rd[i];
      end
   end

endmodule

// File: rtl/regf_wb_ctrl.sv
// Writeback arbiter for the register-file write port: ALU first, then queued LSU, then LSU bypass.
// Latency: one cycle from an accepted beat to wr; a queued LSU beat waits behind older entries.
// Backpressure: ALU is always accepted; LSU sees lsu_ready low while the FIFO is full (no pass-through).
//
// Ports:
//   clk, rst                        clock, async active-high reset
//   alu_valid/alu_rd/alu_data       ALU result, highest priority, never stalled
//   lsu_valid/lsu_ready/lsu_rd/...  LSU result with valid/ready handshake
//   wr/Ad_rd/rd_data_in             registered write to the register file
//   chk_rs1/chk_rs2, rs1/rs2_pend   hazard queries against uncommitted writes
//   count                           LSU FIFO occupancy
module regf_wb_ctrl
   import regf_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int DEPTH = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    alu_valid,
   input  logic [REG_ADDR_W-1:0]   alu_rd,
   input  logic [XLEN-1:0]         alu_data,
   input  logic                    lsu_valid,
   output logic                    lsu_ready,
   input  logic [REG_ADDR_W-1:0]   lsu_rd,
   input  logic [XLEN-1:0]         lsu_data,
   output logic                    wr,
   output logic [REG_ADDR_W-1:0]   Ad_rd,
   output logic [XLEN-1:0]         rd_data_in,
   input  logic [REG_ADDR_W-1:0]   chk_rs1,
   input  logic [REG_ADDR_W-1:0]   chk_rs2,
   output logic                    rs1_pend,
   output logic                    rs2_pend,
   output logic [$clog2(DEPTH):0]  count
);

   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic                               alu_hit;
   logic                               lsu_acc;
   logic                               lsu_keep;
   logic                               fifo_empty;
   logic                               fifo_push;
   logic                               fifo_pop;
   logic                               bypass;
   logic [REG_ADDR_W-1:0]              head_rd;
   logic [XLEN-1:0]                    head_data;
   logic [DEPTH-1:0]                   ent_vld;
   logic [DEPTH-1:0][REG_ADDR_W-1:0]   ent_rd;

   // x0 writes are discarded at the door so they never occupy the FIFO or the port.
   assign alu_hit    = alu_valid && (alu_rd != REG_X0);
   assign lsu_ready  = !rst && (count < FULL_CNT);
   assign lsu_acc    = lsu_valid && lsu_ready;
   assign lsu_keep   = lsu_acc && (lsu_rd != REG_X0);
   assign fifo_empty = (count == '0);

   // The head only drains when the ALU leaves the port free; a fresh LSU beat skips
   // the FIFO only when nothing older is queued, which keeps LSU results in order.
   assign fifo_pop   = !alu_hit && !fifo_empty;
   assign bypass     = !alu_hit && fifo_empty && lsu_keep;
   assign fifo_push  = lsu_keep && !bypass;

   wb_fifo #(
      .XLEN  (XLEN),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (fifo_push),
      .push_rd   (lsu_rd),
      .push_data (lsu_data),
      .pop       (fifo_pop),
      .head_rd   (head_rd),
      .head_data (head_data),
      .count     (count),
      .ent_vld   (ent_vld),
      .ent_rd    (ent_rd)
   );

   // Output stage: address/data hold when idle so the register file sees stable inputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr         <= 1'b0;
         Ad_rd      <= '0;
         rd_data_in <= '0;
      end else if (alu_hit) begin
         wr         <= 1'b1;
         Ad_rd      <= alu_rd;
         rd_data_in <= alu_data;
      end else if (!fifo_empty) begin
         wr         <= 1'b1;
         Ad_rd      <= head_rd;
         rd_data_in <= head_data;
      end else if (bypass) begin
         wr         <= 1'b1;
         Ad_rd      <= lsu_rd;
         rd_data_in <= lsu_data;
      end else begin
         wr         <= 1'b0;
      end
   end

   // Pending = queued in the FIFO or sitting in the output register awaiting commit.
   // Beats arriving this cycle are deliberately not visible here.
   always_comb begin
      rs1_pend = 1'b0;
      rs2_pend = 1'b0;
      if (wr && (Ad_rd == chk_rs1)) rs1_pend = 1'b1;
      if (wr && (Ad_rd == chk_rs2)) rs2_pend = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         if (ent_vld[i] && (ent_rd[i] == chk_rs1)) rs1_pend = 1'b1;
         if (ent_vld[i] && (ent_rd[i] == chk_rs2)) rs2_pend = 1'b1;
      end
      if (chk_rs1 == REG_X0) rs1_pend = 1'b0;
      if (chk_rs2 == REG_X0) rs2_pend = 1'b0;
   end

endmodule

// File: tb/tb_regf_wb_ctrl.sv
// Directed bench for regf_wb_ctrl: vector table for single-cycle behaviour plus hand sequences.
// Latency: n/a.
// Backpressure: n/a.
module tb_regf_wb_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        alu_valid = 1'b0;
   logic [4:0]  alu_rd = 5'd0;
   logic [31:0] alu_data = 32'd0;
   logic        lsu_valid = 1'b0;
   logic        lsu_ready;
   logic [4:0]  lsu_rd = 5'd0;
   logic [31:0] lsu_data = 32'd0;
   logic        wr;
   logic [4:0]  Ad_rd;
   logic [31:0] rd_data_in;
   logic [4:0]  chk_rs1 = 5'd0;
   logic [4:0]  chk_rs2 = 5'd0;
   logic        rs1_pend;
   logic        rs2_pend;
   logic [2:0]  count;

   int errors = 0;
   int checks = 0;

   regf_wb_ctrl #(.XLEN(32), .DEPTH(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .alu_valid  (alu_valid),
      .alu_rd     (alu_rd),
      .alu_data   (alu_data),
      .lsu_valid  (lsu_valid),
      .lsu_ready  (lsu_ready),
      .lsu_rd     (lsu_rd),
      .lsu_data   (lsu_data),
      .wr         (wr),
      .Ad_rd      (Ad_rd),
      .rd_data_in (rd_data_in),
      .chk_rs1    (chk_rs1),
      .chk_rs2    (chk_rs2),
      .rs1_pend   (rs1_pend),
      .rs2_pend   (rs2_pend),
      .count      (count)
   );

   always #5 clk = ~clk;

   // Tiny register-file model committing whatever the controller presents.
   logic [31:0] rf [32];
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) rf[i] <= 32'd0;
      end else if (wr) begin
         rf[Ad_rd] <= rd_data_in;
      end
   end

   typedef struct {
      logic        av;
      logic [4:0]  ard;
      logic [31:0] adat;
      logic        lv;
      logic [4:0]  lrd;
      logic [31:0] ldat;
      logic [4:0]  c1;
      logic [4:0]  c2;
      logic        ewr;
      logic [4:0]  ead;
      logic [31:0] edat;
      logic [2:0]  ecnt;
      logic        erdy;
      logic        ep1;
      logic        ep2;
   } vec_t;

   localparam int NV = 12;
   vec_t vecs [NV];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      //            av    ard    adat           lv    lrd    ldat           c1     c2     ewr   ead    edat           ecnt  rdy   p1    p2
      vecs[0]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        5'd0, 5'd0, 1'b0, 5'd0, 32'h0,        3'd0, 1'b1, 1'b0, 1'b0};
      vecs[1]  = '{1'b1, 5'd1, 32'h11111111, 1'b0, 5'd0, 32'h0,        5'd1, 5'd0, 1'b1, 5'd1, 32'h11111111, 3'd0, 1'b1, 1'b1, 1'b0};
      vecs[2]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        5'd1, 5'd0, 1'b0, 5'd1, 32'h11111111, 3'd0, 1'b1, 1'b0, 1'b0};
      vecs[3]  = '{1'b1, 5'd2, 32'hA,        1'b1, 5'd3, 32'hB,        5'd3, 5'd2, 1'b1, 5'd2, 32'hA,        3'd1, 1'b1, 1'b1, 1'b1};
      vecs[4]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd4, 32'hC,        5'd3, 5'd4, 1'b1, 5'd3, 32'hB,        3'd1, 1'b1, 1'b1, 1'b1};
      vecs[5]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        5'd3, 5'd4, 1'b1, 5'd4, 32'hC,        3'd0, 1'b1, 1'b0, 1'b1};
      vecs[6]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        5'd4, 5'd3, 1'b0, 5'd4, 32'hC,        3'd0, 1'b1, 1'b0, 1'b0};
      vecs[7]  = '{1'b1, 5'd0, 32'hDEAD,     1'b1, 5'd0, 32'hBEEF,     5'd0, 5'd4, 1'b0, 5'd4, 32'hC,        3'd0, 1'b1, 1'b0, 1'b0};
      vecs[8]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd7, 32'h77,       5'd7, 5'd0, 1'b1, 5'd7, 32'h77,       3'd0, 1'b1, 1'b1, 1'b0};
      vecs[9]  = '{1'b1, 5'd8, 32'h88,       1'b1, 5'd0, 32'h1234,     5'd0, 5'd8, 1'b1, 5'd8, 32'h88,       3'd0, 1'b1, 1'b0, 1'b1};
      vecs[10] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd9, 32'h99,       5'd9, 5'd8, 1'b1, 5'd9, 32'h99,       3'd0, 1'b1, 1'b1, 1'b0};
      vecs[11] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        5'd9, 5'd0, 1'b0, 5'd9, 32'h99,       3'd0, 1'b1, 1'b0, 1'b0};

      // ---- reset held for three cycles while the LSU offers a beat ----
      rst       = 1'b1;
      lsu_valid = 1'b1;
      lsu_rd    = 5'd5;
      lsu_data  = 32'h5555AAAA;
      #1;
      for (int c = 0; c < 3; c++) begin
         tick();
         check($sformatf("rst%0d wr", c),    32'(wr),         32'd0);
         check($sformatf("rst%0d Ad_rd", c), 32'(Ad_rd),      32'd0);
         check($sformatf("rst%0d data", c),  rd_data_in,      32'd0);
         check($sformatf("rst%0d ready", c), 32'(lsu_ready),  32'd0);
         check($sformatf("rst%0d count", c), 32'(count),      32'd0);
      end
      lsu_valid = 1'b0;
      lsu_rd    = 5'd0;
      lsu_data  = 32'd0;
      rst       = 1'b0;
      #1;
      check("post-rst ready", 32'(lsu_ready), 32'd1);

      // ---- table-driven single-cycle vectors ----
      for (int i = 0; i < NV; i++) begin
         alu_valid = vecs[i].av;
         alu_rd    = vecs[i].ard;
         alu_data  = vecs[i].adat;
         lsu_valid = vecs[i].lv;
         lsu_rd    = vecs[i].lrd;
         lsu_data  = vecs[i].ldat;
         chk_rs1   = vecs[i].c1;
         chk_rs2   = vecs[i].c2;
         tick();
         check($sformatf("vec%0d wr", i),    32'(wr),        32'(vecs[i].ewr));
         check($sformatf("vec%0d Ad_rd", i), 32'(Ad_rd),     32'(vecs[i].ead));
         check($sformatf("vec%0d data", i),  rd_data_in,     vecs[i].edat);
         check($sformatf("vec%0d count", i), 32'(count),     32'(vecs[i].ecnt));
         check($sformatf("vec%0d ready", i), 32'(lsu_ready), 32'(vecs[i].erdy));
         check($sformatf("vec%0d rs1p", i),  32'(rs1_pend),  32'(vecs[i].ep1));
         check($sformatf("vec%0d rs2p", i),  32'(rs2_pend),  32'(vecs[i].ep2));
      end
      check("rf x1", rf[1], 32'h11111111);
      check("rf x2", rf[2], 32'hA);
      check("rf x3", rf[3], 32'hB);
      check("rf x4", rf[4], 32'hC);
      check("rf x9", rf[9], 32'h99);
      check("rf x0", rf[0], 32'h0);

      // ---- full FIFO under continuous ALU traffic ----
      alu_valid = 1'b1;
      alu_rd    = 5'd5;
      alu_data  = 32'h55;
      chk_rs1   = 5'd10;
      chk_rs2   = 5'd14;
      for (int k = 0; k < 4; k++) begin
         lsu_valid = 1'b1;
         lsu_rd    = 5'(10 + k);
         lsu_data  = 32'hD0 + 32'(k);
         tick();
         check($sformatf("fill%0d count", k), 32'(count), 32'(k + 1));
      end
      check("full ready", 32'(lsu_ready), 32'd0);
      check("full wr",    32'(wr),        32'd1);
      check("full Ad_rd", 32'(Ad_rd),     32'd5);
      check("full rs1p",  32'(rs1_pend),  32'd1);
      check("full rs2p",  32'(rs2_pend),  32'd0);
      lsu_rd   = 5'd14;
      lsu_data = 32'hD4;
      for (int k = 0; k < 2; k++) begin
         tick();
         check($sformatf("stall%0d count", k), 32'(count),     32'd4);
         check($sformatf("stall%0d ready", k), 32'(lsu_ready), 32'd0);
      end
      alu_valid = 1'b0;
      tick();
      check("drain0 Ad_rd", 32'(Ad_rd),     32'd10);
      check("drain0 data",  rd_data_in,     32'hD0);
      check("drain0 count", 32'(count),     32'd3);
      check("drain0 ready", 32'(lsu_ready), 32'd1);
      tick();
      check("drain1 Ad_rd", 32'(Ad_rd),     32'd11);
      check("drain1 data",  rd_data_in,     32'hD1);
      check("drain1 count", 32'(count),     32'd3);
      lsu_valid = 1'b0;
      for (int k = 2; k < 5; k++) begin
         tick();
         check($sformatf("drain%0d wr", k),    32'(wr),    32'd1);
         check($sformatf("drain%0d Ad_rd", k), 32'(Ad_rd), 32'(10 + k));
         check($sformatf("drain%0d data", k),  rd_data_in, 32'hD0 + 32'(k));
         check($sformatf("drain%0d count", k), 32'(count), 32'(4 - k));
      end
      tick();
      check("drained wr", 32'(wr), 32'd0);
      check("rf x14", rf[14], 32'hD4);

      // ---- reset while three LSU writes are queued ----
      alu_valid = 1'b1;
      alu_rd    = 5'd5;
      alu_data  = 32'h55;
      for (int k = 0; k < 3; k++) begin
         lsu_valid = 1'b1;
         lsu_rd    = 5'(20 + k);
         lsu_data  = 32'hE0 + 32'(k);
         tick();
      end
      check("preq count", 32'(count), 32'd3);
      alu_valid = 1'b0;
      lsu_valid = 1'b0;
      chk_rs1   = 5'd20;
      chk_rs2   = 5'd5;
      rst       = 1'b1;
      #1;
      check("mrst wr",    32'(wr),        32'd0);
      check("mrst count", 32'(count),     32'd0);
      check("mrst Ad_rd", 32'(Ad_rd),     32'd0);
      check("mrst ready", 32'(lsu_ready), 32'd0);
      check("mrst rs1p",  32'(rs1_pend),  32'd0);
      check("mrst rs2p",  32'(rs2_pend),  32'd0);
      tick();
      tick();
      rst = 1'b0;
      for (int c = 0; c < 5; c++) begin
         tick();
         check($sformatf("postq%0d wr", c),    32'(wr),    32'd0);
         check($sformatf("postq%0d count", c), 32'(count), 32'd0);
      end
      check("rf x20", rf[20], 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
